// File: rtl/memory_interface_ctrl.sv
// Memory transaction sequencer between control unit, MAR/MDR and external RAM.
// Runs one read or write per request, with ready-handshake wait states and timeout.
module memory_interface_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  mem_read_req,
  input  logic                  mem_write_req,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  input  logic [DATA_WIDTH-1:0] mdr_q,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] MDataIn,
  output logic                  MDR_read,
  output logic                  MDR_enable,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  mem_err
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_LOAD,
    WR_WAIT,
    DONE,
    ERR
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          timeout;

  assign timeout = (wait_cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Read request has priority; a simultaneous write request is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_read_req)       state_nxt = RD_WAIT;
        else if (mem_write_req) state_nxt = WR_WAIT;
      end
      RD_WAIT: begin
        if (ram_ready)    state_nxt = RD_LOAD;
        else if (timeout) state_nxt = ERR;
      end
      RD_LOAD: state_nxt = DONE;
      WR_WAIT: begin
        if (ram_ready)    state_nxt = DONE;
        else if (timeout) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      MDataIn   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read_req || mem_write_req) begin
            ram_addr <= mar_addr;
            wait_cnt <= '0;
          end
          if (!mem_read_req && mem_write_req) ram_wdata <= mdr_q;
        end
        RD_WAIT: begin
          if (ram_ready)     MDataIn  <= ram_rdata;
          else if (!timeout) wait_cnt <= wait_cnt + CW'(1);
        end
        WR_WAIT: begin
          if (!ram_ready && !timeout) wait_cnt <= wait_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ram_re     = (state == RD_WAIT);
  assign ram_we     = (state == WR_WAIT);
  assign MDR_read   = (state == RD_LOAD);
  assign MDR_enable = (state == RD_LOAD);
  assign mem_busy   = (state != IDLE);
  assign mem_done   = (state == DONE) || (state == ERR);
  assign mem_err    = (state == ERR);

endmodule
